// File: rtl/mac_pkg.sv
// Shared constants and types for the MAC operand feeder and its operand FIFO.
package mac_pkg;

    localparam int DATA_W = 32;
    localparam int ACC_W  = 2 * DATA_W + 1;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        FEED  = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2,
        CLEAR = 2'd3
    } feeder_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              last;
    } fifo_entry_t;

endpackage

// File: rtl/mac_operand_fifo.sv
// Small synchronous FIFO of operand pairs; count is registered so full/empty are glitch-free.
module mac_operand_fifo
    import mac_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  fifo_entry_t push_data,
    input  logic        pop,
    output fifo_entry_t pop_data,
    output logic        full,
    output logic        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    fifo_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             push_ok;
    logic             pop_ok;

    // A full FIFO refuses pushes even when a pop frees a slot this cycle.
    assign full    = (count_reg == FULL_CNT);
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr_reg];

endmodule

// File: rtl/mac_operand_feeder.sv
// Feeds buffered operand pairs to the MAC, captures the drained accumulator per vector.
// Define MAC_FEED_CNT_EN to add the res_count output (pairs popped per captured vector).
module mac_operand_feeder #(
    parameter int DATA_W  = mac_pkg::DATA_W,
    parameter int ACC_W   = mac_pkg::ACC_W,
    parameter int DEPTH   = 4,
    parameter int MAC_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_a,
    input  logic [DATA_W-1:0] s_b,
    input  logic              s_last,
    output logic [DATA_W-1:0] multiplicand,
    output logic [DATA_W-1:0] multiplier,
    output logic              mac_clr,
    input  logic [ACC_W-1:0]  accumulator_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
`ifdef MAC_FEED_CNT_EN
    output logic [15:0]       res_count,
`endif
    output logic              busy
);

    import mac_pkg::*;

    localparam int DCNT_W = $clog2(MAC_LAT + 2);
    localparam logic [DCNT_W-1:0] DRAIN_INIT = DCNT_W'(MAC_LAT);

    feeder_state_t     state_reg, state_next;
    logic [DCNT_W-1:0] drain_cnt_reg, drain_cnt_next;
    logic [DATA_W-1:0] multiplicand_reg, multiplicand_next;
    logic [DATA_W-1:0] multiplier_reg, multiplier_next;
    logic              mac_clr_reg, mac_clr_next;
    logic              res_valid_reg, res_valid_next;
    logic [ACC_W-1:0]  res_data_reg, res_data_next;
    logic              pop;
    logic              capture;

    fifo_entry_t push_entry;
    fifo_entry_t pop_entry;
    logic        fifo_full;
    logic        fifo_empty;

    assign push_entry = '{a: s_a, b: s_b, last: s_last};

    mac_operand_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (s_valid),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (pop_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= FEED;
            drain_cnt_reg    <= '0;
            multiplicand_reg <= '0;
            multiplier_reg   <= '0;
            mac_clr_reg      <= 1'b0;
            res_valid_reg    <= 1'b0;
            res_data_reg     <= '0;
        end else begin
            state_reg        <= state_next;
            drain_cnt_reg    <= drain_cnt_next;
            multiplicand_reg <= multiplicand_next;
            multiplier_reg   <= multiplier_next;
            mac_clr_reg      <= mac_clr_next;
            res_valid_reg    <= res_valid_next;
            res_data_reg     <= res_data_next;
        end
    end

    // Operands default to zero so the accumulator is untouched on bubbles and outside FEED.
    always_comb begin
        state_next        = state_reg;
        drain_cnt_next    = drain_cnt_reg;
        multiplicand_next = '0;
        multiplier_next   = '0;
        mac_clr_next      = 1'b0;
        res_valid_next    = res_valid_reg;
        res_data_next     = res_data_reg;
        pop               = 1'b0;
        capture           = 1'b0;
        unique case (state_reg)
            FEED: begin
                if (!fifo_empty) begin
                    pop               = 1'b1;
                    multiplicand_next = pop_entry.a;
                    multiplier_next   = pop_entry.b;
                    if (pop_entry.last) begin
                        state_next     = DRAIN;
                        drain_cnt_next = DRAIN_INIT;
                    end
                end
            end
            DRAIN: begin
                // Counter reaches zero once the last product has landed in the accumulator.
                if (drain_cnt_reg == '0) begin
                    capture        = 1'b1;
                    res_data_next  = accumulator_out;
                    res_valid_next = 1'b1;
                    state_next     = HOLD;
                end else begin
                    drain_cnt_next = drain_cnt_reg - 1'b1;
                end
            end
            HOLD: begin
                if (res_valid_reg && res_ready) begin
                    res_valid_next = 1'b0;
                    mac_clr_next   = 1'b1;
                    state_next     = CLEAR;
                end
            end
            CLEAR: begin
                state_next = FEED;
            end
            default: begin
                state_next = FEED;
            end
        endcase
    end

`ifdef MAC_FEED_CNT_EN
    logic [15:0] elem_cnt_reg;
    logic [15:0] res_count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            elem_cnt_reg  <= '0;
            res_count_reg <= '0;
        end else begin
            if (state_reg == HOLD && state_next == CLEAR) begin
                elem_cnt_reg <= '0;
            end else if (pop && elem_cnt_reg != 16'hFFFF) begin
                elem_cnt_reg <= elem_cnt_reg + 16'd1;
            end
            if (capture) begin
                res_count_reg <= elem_cnt_reg;
            end
        end
    end

    assign res_count = res_count_reg;
`endif

    assign s_ready      = !fifo_full;
    assign multiplicand = multiplicand_reg;
    assign multiplier   = multiplier_reg;
    assign mac_clr      = mac_clr_reg;
    assign res_valid    = res_valid_reg;
    assign res_data     = res_data_reg;
    assign busy         = !(state_reg == FEED && fifo_empty);

endmodule
